// File: rtl/lsu_router_pkg.sv
// Shared types and constants for the LSU read-data router.
//   router_state_t : FSM encoding (IDLE, WAIT, RESP)
//   ERR_DATA       : data returned with every error response
//   ERR_CNT_W      : width of the saturating error counter
//   sel_w()        : width of a slave index (at least 1 bit)
package lsu_router_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} router_state_t;

  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
  localparam int          ERR_CNT_W = 16;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_region_decoder.sv
// Combinational address decoder: compares an address against N_SLV base/mask
// regions and reports whether any region matched plus the index of the lowest
// matching region.
//   addr : access byte address
//   hit  : at least one region matched
//   sel  : index of the lowest matching region (0 when no hit)
module addr_region_decoder
  import lsu_router_pkg::*;
#(
  parameter int                          N_SLV = 4,
  parameter int                          AW    = 32,
  parameter logic [N_SLV-1:0][AW-1:0]    BASE  = {32'h4000_0000, 32'h8000_0000,
                                                  32'h0000_0000, 32'h0000_0000},
  parameter logic [N_SLV-1:0][AW-1:0]    MASK  = {32'hF000_0000, 32'hF000_0000,
                                                  32'hFFFE_0000, 32'hFFFF_FF00}
) (
  input  logic [AW-1:0]           addr,
  output logic                    hit,
  output logic [sel_w(N_SLV)-1:0] sel
);

  localparam int SW = sel_w(N_SLV);

  logic [N_SLV-1:0] hits;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_region
    assign hits[gi] = ((addr & MASK[gi]) == BASE[gi]);
  end

  // Scan from the top down so the lowest matching index is the last written.
  always_comb begin
    hit = |hits;
    sel = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hits[i]) sel = SW'(i);
    end
  end

endmodule

// File: rtl/lsu_rdata_router.sv
// Handshaked LSU load-data router. Decodes each accepted LSU request to one
// slave region, strobes that slave for one cycle, waits for its ack (bounded
// by TIMEOUT cycles) and returns a one-cycle response. Unmapped addresses and
// timeouts return ERR_DATA with rsp_err set. One transaction at a time.
//   req_valid/req_addr/req_we/req_ready : LSU request handshake
//   slv_req   : one-hot request strobe, combinational in the accept cycle
//   slv_ack   : per-slave completion strobe
//   slv_rdata : per-slave read data, slave i at [i*DW +: DW]
//   rsp_valid/rsp_rdata/rsp_err : response to the LSU (data/err held)
//   err_cnt   : saturating count of error responses
module lsu_rdata_router
  import lsu_router_pkg::*;
#(
  parameter int                          N_SLV   = 4,
  parameter int                          AW      = 32,
  parameter int                          DW      = 32,
  parameter logic [N_SLV-1:0][AW-1:0]    BASE    = {32'h4000_0000, 32'h8000_0000,
                                                    32'h0000_0000, 32'h0000_0000},
  parameter logic [N_SLV-1:0][AW-1:0]    MASK    = {32'hF000_0000, 32'hF000_0000,
                                                    32'hFFFE_0000, 32'hFFFF_FF00},
  parameter int                          TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [AW-1:0]         req_addr,
  input  logic                  req_we,
  output logic                  req_ready,
  output logic [N_SLV-1:0]      slv_req,
  input  logic [N_SLV-1:0]      slv_ack,
  input  logic [N_SLV*DW-1:0]   slv_rdata,
  output logic                  rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int SW = sel_w(N_SLV);
  localparam int CW = 8;

  router_state_t         state;
  logic [SW-1:0]         sel_q;
  logic                  we_q;
  logic [CW-1:0]         cnt;
  logic [ERR_CNT_W-1:0]  err_cnt_q;

  logic                  dec_hit;
  logic [SW-1:0]         dec_sel;
  logic                  accept;
  logic [DW-1:0]         rdata_arr [N_SLV];

  addr_region_decoder #(
    .N_SLV (N_SLV),
    .AW    (AW),
    .BASE  (BASE),
    .MASK  (MASK)
  ) u_dec (
    .addr (req_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign err_cnt   = err_cnt_q;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_slv
    assign slv_req[gi]   = accept && dec_hit && (dec_sel == SW'(gi));
    assign rdata_arr[gi] = slv_rdata[gi*DW +: DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      err_cnt_q <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q <= req_we;
            if (dec_hit) begin
              sel_q <= dec_sel;
              cnt   <= '0;
              state <= WAIT;
            end else begin
              rsp_rdata <= DW'(ERR_DATA);
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        WAIT: begin
          // Only the selected slave's ack counts; an ack in the final
          // allowed cycle still beats the timeout.
          if (slv_ack[sel_q]) begin
            rsp_rdata <= we_q ? '0 : rdata_arr[sel_q];
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_rdata <= DW'(ERR_DATA);
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          if (rsp_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rdata_router.sv
// Self-checking bench for lsu_rdata_router: directed vector table, hand-written
// corner sequences (late ack, reset in WAIT, counter saturation) and random
// transactions checked against a behavioural model of the routing rules.
module tb_lsu_rdata_router;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam logic [N-1:0][AW-1:0] BASE = {32'h4000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [N-1:0][AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hFFFE_0000, 32'hFFFF_FF00};
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic [AW-1:0]   req_addr;
  logic            req_we;
  logic            req_ready;
  logic [N-1:0]    slv_req;
  logic [N-1:0]    slv_ack;
  logic [N*DW-1:0] slv_rdata;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [15:0]     err_cnt;

  lsu_rdata_router #(
    .N_SLV(N), .AW(AW), .DW(DW), .BASE(BASE), .MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we),
    .req_ready(req_ready), .slv_req(slv_req), .slv_ack(slv_ack), .slv_rdata(slv_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_cnt  = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: lowest matching region wins; mapped requests complete on the
  // ack cycle + 1 if the ack arrives within TO cycles, otherwise error at TO+1.
  task automatic model(input logic [31:0] addr, input logic we, input int ack_d,
                       input logic [31:0] rdata, output int sel, output int lat,
                       output logic [31:0] data, output logic err);
    sel = -1;
    for (int i = 0; i < N; i++)
      if (sel < 0 && ((addr & MASK[i]) == BASE[i])) sel = i;
    if (sel < 0) begin
      lat = 1; data = ERRD; err = 1'b1;
    end else if (ack_d >= 1 && ack_d <= TO) begin
      lat = ack_d + 1; data = we ? 32'h0 : rdata; err = 1'b0;
    end else begin
      lat = TO + 1; data = ERRD; err = 1'b1;
    end
  endtask

  // One transaction: request in cycle T, then observe cycles T+1.. until a
  // response appears (bounded), driving the selected ack and optional noise.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic we,
                         input int ack_slv, input int ack_d, input logic [31:0] rdata,
                         input int noise_slv, input int noise_cyc, input logic [3:0] exp_req,
                         input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
    int          lat;
    logic        bad_req;
    logic [31:0] held;
    lat = 0;
    bad_req = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_we = we;
    slv_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    chk({name, " ready"}, {31'h0, req_ready}, 32'h1);
    chk({name, " slv_req"}, {28'h0, slv_req}, {28'h0, exp_req});
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      slv_ack = '0;
      slv_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (noise_slv >= 0 && k == noise_cyc) slv_ack[noise_slv] = 1'b1;
      if (ack_slv >= 0 && k == ack_d) begin
        slv_ack[ack_slv] = 1'b1;
        slv_rdata[ack_slv*DW +: DW] = rdata;
      end
      #1;
      if (slv_req != '0) bad_req = 1'b1;
      if (rsp_valid) lat = k;
    end
    slv_ack = '0;
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " rdata"}, rsp_rdata, exp_data);
    chk({name, " err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    chk({name, " no extra slv_req"}, {31'h0, bad_req}, 32'h0);
    if (exp_err && exp_cnt != 16'hFFFF) exp_cnt++;
    held = rsp_rdata;
    $display("txn %s addr=%h we=%0b lat=%0d rdata=%h err=%0b", name, addr, we, lat, rsp_rdata, rsp_err);
    @(negedge clk);
    #1;
    chk({name, " one-cycle valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({name, " rdata held"}, rsp_rdata, held);
    chk({name, " err_cnt"}, {16'h0, err_cnt}, {16'h0, exp_cnt});
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    int          ack_slv;
    int          ack_d;
    logic [31:0] rdata;
    int          noise_slv;
    int          noise_cyc;
    logic [3:0]  exp_req;
    int          exp_lat;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        flag;
    int          sel, lat, ack_d, noise, r;
    logic [31:0] addr, rdata, data;
    logic        we, err;

    vecs[0] = '{"dmem_load",  32'h0000_0040, 1'b0, 0,  1, 32'h1234_5678, -1, 0, 4'b0001, 2,  32'h1234_5678, 1'b0};
    vecs[1] = '{"slv1_only",  32'h0000_1000, 1'b0, 1,  2, 32'hAAAA_0001, -1, 0, 4'b0010, 3,  32'hAAAA_0001, 1'b0};
    vecs[2] = '{"overlap",    32'h0000_0010, 1'b0, 0,  1, 32'h5555_0002, -1, 0, 4'b0001, 2,  32'h5555_0002, 1'b0};
    vecs[3] = '{"store",      32'h0000_0020, 1'b1, 0,  1, 32'h7777_7777, -1, 0, 4'b0001, 2,  32'h0000_0000, 1'b0};
    vecs[4] = '{"unmapped",   32'h2000_0000, 1'b0, -1, 0, 32'h0,         -1, 0, 4'b0000, 1,  32'hDEAD_BEEF, 1'b1};
    vecs[5] = '{"timeout",    32'h8000_0004, 1'b0, 2,  0, 32'h0,         -1, 0, 4'b0100, 16, 32'hDEAD_BEEF, 1'b1};
    vecs[6] = '{"wrong_ack",  32'h8000_0010, 1'b0, 2,  3, 32'hCAFE_0001,  3, 1, 4'b0100, 4,  32'hCAFE_0001, 1'b0};
    vecs[7] = '{"ack_at_to",  32'h4000_1234, 1'b0, 3, 15, 32'h0BAD_F00D, -1, 0, 4'b1000, 16, 32'h0BAD_F00D, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; slv_ack = '0; slv_rdata = '0;
    #1;
    chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset err_cnt", {16'h0, err_cnt}, 32'h0);
    chk("reset req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++)
      run_txn(vecs[v].name, vecs[v].addr, vecs[v].we, vecs[v].ack_slv, vecs[v].ack_d,
              vecs[v].rdata, vecs[v].noise_slv, vecs[v].noise_cyc, vecs[v].exp_req,
              vecs[v].exp_lat, vecs[v].exp_data, vecs[v].exp_err);

    // Late ack while idle must not produce a response.
    flag = 1'b0;
    @(negedge clk); slv_ack[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); slv_ack = '0; #1;
      if (rsp_valid) flag = 1'b1;
    end
    chk("late ack ignored", {31'h0, flag}, 32'h0);

    // Reset while waiting on a silent slave.
    @(negedge clk); req_valid = 1'b1; req_addr = 32'h8000_0100; req_we = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; #1;
    chk("rst slv_req", {28'h0, slv_req}, 32'h0);
    chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    chk("rst rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst err_cnt", {16'h0, err_cnt}, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post-rst ready", {31'h0, req_ready}, 32'h1);
    exp_cnt = 16'h0;
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) flag = 1'b1;
    end
    chk("no stale response", {31'h0, flag}, 32'h0);

    // Random transactions against the model.
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 4);
      case (r)
        0:       addr = 32'($urandom_range(0, 255));
        1:       addr = 32'($urandom_range(32'h100, 32'h1FFFF));
        2:       addr = 32'h8000_0000 | ($urandom() & 32'h0FFF_FFFF);
        3:       addr = 32'h4000_0000 | ($urandom() & 32'h0FFF_FFFF);
        default: addr = $urandom();
      endcase
      we    = 1'($urandom_range(0, 1));
      ack_d = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 18);
      rdata = $urandom();
      model(addr, we, ack_d, rdata, sel, lat, data, err);
      noise = (sel >= 0) ? ((sel + $urandom_range(1, N - 1)) % N) : -1;
      run_txn("rand", addr, we, sel, ack_d, rdata, noise, $urandom_range(1, 6),
              (sel >= 0) ? 4'(1 << sel) : 4'b0000, lat, data, err);
    end

    // Saturation of the error counter.
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFE;
    #1;
    release dut.err_cnt_q;
    #1;
    chk("err_cnt preset", {16'h0, err_cnt}, 32'h0000_FFFE);
    exp_cnt = 16'hFFFE;
    run_txn("sat1", 32'h2000_0000, 1'b0, -1, 0, 32'h0, -1, 0, 4'b0000, 1, ERRD, 1'b1);
    run_txn("sat2", 32'h3000_0000, 1'b0, -1, 0, 32'h0, -1, 0, 4'b0000, 1, ERRD, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
